// File: rtl/lfsr16_checker.sv
`default_nettype none
// ============================================================================
// Module      : lfsr16_checker
// Description : PRBS checker for x^16+x^14+x^13+x^11+1. Hunts for 16 seed
//               bits, verifies LOCK_CNT predicted bits, then tracks the stream
//               in LOCKED, counting errors and dropping lock when too many
//               errors land inside one error window.
// Revision    : 1.0 - initial release
// ============================================================================
module lfsr16_checker #(
  parameter int LOCK_CNT   = 32,
  parameter int ERR_WIN    = 64,
  parameter int ERR_THRESH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_vld,
  input  logic        in_bit,
  input  logic        clr,
  output logic        locked,
  output logic        err_pulse,
  output logic [15:0] err_count,
  output logic [31:0] bit_count,
  output logic [1:0]  sync_state
);

  localparam int c_MATCH_W = $clog2(LOCK_CNT + 1);
  localparam int c_WIN_W   = (ERR_WIN > 1) ? $clog2(ERR_WIN) : 1;
  localparam int c_WERR_W  = $clog2(ERR_THRESH + 1);

  localparam logic [c_MATCH_W-1:0] c_MATCH_LAST = c_MATCH_W'(LOCK_CNT - 1);
  localparam logic [c_WIN_W-1:0]   c_WIN_LAST   = c_WIN_W'(ERR_WIN - 1);
  localparam logic [c_WERR_W-1:0]  c_ERR_THRESH = c_WERR_W'(ERR_THRESH);

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [15:0]           s_q, s_d;
  logic [4:0]            fill_q, fill_d;
  logic [c_MATCH_W-1:0]  match_q, match_d;
  logic [c_WIN_W-1:0]    win_bit_q, win_bit_d;
  logic [c_WERR_W-1:0]   win_err_q, win_err_d;
  logic [15:0]           err_cnt_q, err_cnt_d;
  logic [31:0]           bit_cnt_q, bit_cnt_d;
  logic                  err_pulse_q, err_pulse_d;
  logic                  locked_q;

  logic                  w_pred;
  logic                  w_miss_verify;
  logic                  w_miss_locked;
  logic [c_WERR_W-1:0]   w_win_err_inc;

  // Predicted bit and the two flavours of mismatch; an all-zero register can
  // never be a real PRBS state so VERIFY treats it as a failure.
  always_comb begin
    w_pred        = s_q[15] ^ s_q[13] ^ s_q[12] ^ s_q[10];
    w_miss_locked = (in_bit != w_pred);
    w_miss_verify = w_miss_locked || (s_q == 16'h0000);
    w_win_err_inc = win_err_q + c_WERR_W'(w_miss_locked);
  end

  // Next-state logic: sync FSM, shift register, window and statistic counters.
  always_comb begin
    state_d     = state_q;
    s_d         = s_q;
    fill_d      = fill_q;
    match_d     = match_q;
    win_bit_d   = win_bit_q;
    win_err_d   = win_err_q;
    err_cnt_d   = err_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    err_pulse_d = 1'b0;

    if (in_vld) begin
      case (state_q)
        ST_HUNT: begin
          s_d = {s_q[14:0], in_bit};
          if (fill_q == 5'd15) begin
            state_d = ST_VERIFY;
            fill_d  = 5'd0;
            match_d = '0;
          end else begin
            fill_d = fill_q + 5'd1;
          end
        end

        ST_VERIFY: begin
          s_d = {s_q[14:0], in_bit};
          if (w_miss_verify) begin
            // The offending bit becomes the first bit of a fresh fill.
            state_d = ST_HUNT;
            fill_d  = 5'd1;
            match_d = '0;
          end else if (match_q == c_MATCH_LAST) begin
            state_d   = ST_LOCKED;
            match_d   = '0;
            win_bit_d = '0;
            win_err_d = '0;
          end else begin
            match_d = match_q + c_MATCH_W'(1);
          end
        end

        ST_LOCKED: begin
          // Self-running prediction keeps line errors out of the register.
          s_d = {s_q[14:0], w_pred};
          if (bit_cnt_q != 32'hFFFF_FFFF) begin
            bit_cnt_d = bit_cnt_q + 32'd1;
          end
          if (w_miss_locked) begin
            err_pulse_d = 1'b1;
            if (err_cnt_q != 16'hFFFF) begin
              err_cnt_d = err_cnt_q + 16'd1;
            end
          end
          if (w_win_err_inc >= c_ERR_THRESH) begin
            state_d   = ST_HUNT;
            fill_d    = 5'd0;
            win_bit_d = '0;
            win_err_d = '0;
          end else if (win_bit_q == c_WIN_LAST) begin
            win_bit_d = '0;
            win_err_d = '0;
          end else begin
            win_bit_d = win_bit_q + c_WIN_W'(1);
            win_err_d = w_win_err_inc;
          end
        end

        default: begin
          state_d = ST_HUNT;
          fill_d  = 5'd0;
        end
      endcase
    end

    // Clear wins over any increment computed above; FSM and S are untouched.
    if (clr) begin
      err_cnt_d = 16'd0;
      bit_cnt_d = 32'd0;
    end
  end

  // State register with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_HUNT;
      s_q         <= 16'h0000;
      fill_q      <= 5'd0;
      match_q     <= '0;
      win_bit_q   <= '0;
      win_err_q   <= '0;
      err_cnt_q   <= 16'd0;
      bit_cnt_q   <= 32'd0;
      err_pulse_q <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      fill_q      <= fill_d;
      match_q     <= match_d;
      win_bit_q   <= win_bit_d;
      win_err_q   <= win_err_d;
      err_cnt_q   <= err_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      err_pulse_q <= err_pulse_d;
      locked_q    <= (state_d == ST_LOCKED);
    end
  end

  assign locked     = locked_q;
  assign err_pulse  = err_pulse_q;
  assign err_count  = err_cnt_q;
  assign bit_count  = bit_cnt_q;
  assign sync_state = state_q;

endmodule
`default_nettype wire

// File: tb/tb_lfsr16_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_lfsr16_checker
// Description : Self-checking bench for lfsr16_checker: vector table,
//               directed lock/loss/clear sequences, randomized traffic against
//               a queue-based reference model, and counter saturation on a
//               second instance whose error threshold can never be reached.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lfsr16_checker;

  localparam int LOCK_CNT   = 32;
  localparam int ERR_WIN    = 64;
  localparam int ERR_THRESH = 4;

  logic        clk = 1'b0;
  logic        rst, in_vld, in_bit, clr;
  logic        locked, err_pulse;
  logic [15:0] err_count;
  logic [31:0] bit_count;
  logic [1:0]  sync_state;

  logic        s_rst, s_vld, s_bit, s_clr;
  logic        s_locked, s_err_pulse;
  logic [15:0] s_err_count;
  logic [31:0] s_bit_count;
  logic [1:0]  s_sync_state;

  always #5 clk = ~clk;

  lfsr16_checker #(.LOCK_CNT(LOCK_CNT), .ERR_WIN(ERR_WIN), .ERR_THRESH(ERR_THRESH)) dut (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_bit(in_bit), .clr(clr),
    .locked(locked), .err_pulse(err_pulse), .err_count(err_count),
    .bit_count(bit_count), .sync_state(sync_state)
  );

  // Window of 4 bits can hold at most 4 errors, so a threshold of 8 never trips.
  lfsr16_checker #(.LOCK_CNT(32), .ERR_WIN(4), .ERR_THRESH(8)) u_sat (
    .clk(clk), .rst(s_rst), .in_vld(s_vld), .in_bit(s_bit), .clr(s_clr),
    .locked(s_locked), .err_pulse(s_err_pulse), .err_count(s_err_count),
    .bit_count(s_bit_count), .sync_state(s_sync_state)
  );

  int nchecks = 0;
  int nfail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchecks++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // PRBS source: emits the predicted bit and advances its own state.
  function automatic bit lfsr_adv(inout logic [15:0] g);
    bit b;
    b = g[15] ^ g[13] ^ g[12] ^ g[10];
    g = {g[14:0], b};
    return b;
  endfunction

  // ---------------- reference model ----------------
  // hist[k] holds the bit entered k+1 valid bits ago (hist[0] newest).
  bit     hist[$];
  int     m_mode, m_fill, m_match, m_wpos, m_werr;
  longint m_errc, m_bitc;
  bit     m_pulse;

  task automatic model_reset();
    hist = {};
    for (int k = 0; k < 16; k++) hist.push_back(1'b0);
    m_mode = 0; m_fill = 0; m_match = 0; m_wpos = 0; m_werr = 0;
    m_errc = 0; m_bitc = 0; m_pulse = 1'b0;
  endtask

  task automatic model_push(input bit b);
    hist.push_front(b);
    void'(hist.pop_back());
  endtask

  task automatic model_step(input bit r, input bit v, input bit b, input bit c);
    bit p, zero;
    if (r) begin
      model_reset();
      return;
    end
    m_pulse = 1'b0;
    if (v) begin
      p = hist[15] ^ hist[13] ^ hist[12] ^ hist[10];
      zero = 1'b1;
      foreach (hist[k]) if (hist[k]) zero = 1'b0;
      if (m_mode == 0) begin
        model_push(b);
        m_fill++;
        if (m_fill == 16) begin m_mode = 1; m_match = 0; end
      end else if (m_mode == 1) begin
        model_push(b);
        if (b != p || zero) begin
          m_mode = 0; m_fill = 1;
        end else begin
          m_match++;
          if (m_match == LOCK_CNT) begin m_mode = 2; m_wpos = 0; m_werr = 0; end
        end
      end else begin
        model_push(p);
        m_bitc = (m_bitc < 64'hFFFF_FFFF) ? m_bitc + 1 : m_bitc;
        if (b != p) begin
          m_pulse = 1'b1;
          m_errc  = (m_errc < 65535) ? m_errc + 1 : m_errc;
          m_werr++;
        end
        if (m_werr >= ERR_THRESH) begin
          m_mode = 0; m_fill = 0; m_wpos = 0; m_werr = 0;
        end else begin
          m_wpos++;
          if (m_wpos == ERR_WIN) begin m_wpos = 0; m_werr = 0; end
        end
      end
    end
    if (c) begin m_errc = 0; m_bitc = 0; end
  endtask

  function automatic logic [63:0] dut_vec();
    return {12'd0, locked, err_pulse, err_count, bit_count, sync_state};
  endfunction

  function automatic logic [63:0] model_vec();
    return {12'd0, (m_mode == 2), m_pulse, 16'(m_errc), 32'(m_bitc), 2'(m_mode)};
  endfunction

  // One clock of stimulus on the main DUT, checked against the model.
  task automatic step(input bit r, input bit v, input bit b, input bit c);
    rst = r; in_vld = v; in_bit = b; clr = c;
    @(posedge clk);
    model_step(r, v, b, c);
    #1;
    chk("model", dut_vec(), model_vec());
  endtask

  logic [15:0] g_main;

  task automatic send(input bit flip, input bit c);
    bit b;
    b = lfsr_adv(g_main);
    step(1'b0, 1'b1, b ^ flip, c);
  endtask

  typedef struct {
    bit        r, v, b, c;
    bit        lk;
    bit [1:0]  st;
    bit [15:0] ec;
    bit [31:0] bc;
  } vec_t;

  vec_t tbl[19];

  task automatic main_test();
    int saw_hunt, saw_verify, saw_lock;
    bit flip_rate_hi, flip_rate_lo;

    // Vector table: reset with valid high, then the 16-bit fill of the stream.
    g_main = 16'he45b;
    for (int i = 0; i < 2; i++) tbl[i] = '{r:1, v:1, b:1, c:0, lk:0, st:2'd0, ec:16'd0, bc:32'd0};
    for (int i = 2; i < 18; i++) begin
      tbl[i] = '{r:0, v:1, b:lfsr_adv(g_main), c:0, lk:0, st:((i == 17) ? 2'd1 : 2'd0), ec:16'd0, bc:32'd0};
    end
    tbl[18] = '{r:0, v:0, b:1, c:0, lk:0, st:2'd1, ec:16'd0, bc:32'd0};

    for (int i = 0; i < 19; i++) begin
      step(tbl[i].r, tbl[i].v, tbl[i].b, tbl[i].c);
      chk($sformatf("vec%0d", i), {12'd0, locked, sync_state, err_count, bit_count},
          {12'd0, tbl[i].lk, tbl[i].st, tbl[i].ec, tbl[i].bc});
    end

    // Acquisition: 31 more matches keeps VERIFY, the 32nd locks (bit 48).
    repeat (31) send(1'b0, 1'b0);
    chk("acq_47_unlocked", 64'(locked), 64'd0);
    send(1'b0, 1'b0);
    chk("acq_48_locked", 64'({locked, sync_state}), 64'({1'b1, 2'd2}));
    repeat (100) send(1'b0, 1'b0);
    chk("acq_bitcount_100", 64'(bit_count), 64'd100);
    chk("acq_errcount_0", 64'(err_count), 64'd0);

    // Single error: one-cycle pulse, lock kept.
    send(1'b1, 1'b0);
    chk("single_pulse_hi", 64'({err_pulse, locked, err_count}), 64'({1'b1, 1'b1, 16'd1}));
    send(1'b0, 1'b0);
    chk("single_pulse_lo", 64'(err_pulse), 64'd0);
    repeat (64) send(1'b0, 1'b0);
    chk("single_no_more", 64'({locked, err_count}), 64'({1'b1, 16'd1}));

    // Idle clear; then move to a window boundary (166 locked bits so far).
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("clr_idle", 64'({locked, err_count, bit_count}), 64'({1'b1, 16'd0, 32'd0}));
    repeat (26) send(1'b0, 1'b0);

    // Loss of lock: four errors at window positions 0,3,6,9.
    for (int e = 0; e < 4; e++) begin
      send(1'b1, 1'b0);
      if (e == 2) chk("loss_3rd_still_locked", 64'(locked), 64'd1);
      if (e < 3) repeat (2) send(1'b0, 1'b0);
    end
    chk("loss_after_4th", 64'({locked, sync_state, err_count}), 64'({1'b0, 2'd0, 16'd4}));
    repeat (47) send(1'b0, 1'b0);
    chk("relock_47", 64'({locked, sync_state}), 64'({1'b0, 2'd1}));
    send(1'b0, 1'b0);
    chk("relock_48", 64'({locked, err_count}), 64'({1'b1, 16'd4}));

    // Zero stream never locks; state bounces between HUNT and VERIFY.
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    saw_hunt = 0; saw_verify = 0; saw_lock = 0;
    for (int i = 0; i < 200; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0);
      if (i > 16 && sync_state == 2'd0) saw_hunt++;
      if (sync_state == 2'd1) saw_verify++;
      if (locked) saw_lock++;
    end
    chk("zero_reenters_hunt", 64'(saw_hunt > 0), 64'd1);
    chk("zero_visits_verify", 64'(saw_verify > 1), 64'd1);
    chk("zero_never_locks", 64'(saw_lock), 64'd0);

    // Gapped valid: one valid bit in three cycles.
    step(1'b1, 1'b0, 1'b0, 1'b0);
    g_main = 16'he45b;
    for (int n = 1; n <= 48; n++) begin
      repeat (2) step(1'b0, 1'b0, 1'($urandom % 2), 1'b0);
      send(1'b0, 1'b0);
      if (n == 47) chk("gap_47_unlocked", 64'(locked), 64'd0);
      if (n == 48) chk("gap_48_locked", 64'(locked), 64'd1);
    end

    // clr collision: five spread errors, then an error with clr.
    for (int e = 0; e < 5; e++) begin
      send(1'b1, 1'b0);
      repeat (31) send(1'b0, 1'b0);
    end
    chk("coll_pre_5", 64'({locked, err_count}), 64'({1'b1, 16'd5}));
    send(1'b1, 1'b1);
    chk("coll_clr_wins", 64'({err_pulse, locked, err_count, bit_count}),
        64'({1'b1, 1'b1, 16'd0, 32'd0}));
    send(1'b0, 1'b0);
    chk("coll_after", 64'({err_pulse, err_count, bit_count}), 64'({1'b0, 16'd0, 32'd1}));

    // Randomized traffic against the model with varying error density.
    flip_rate_hi = 1'b0; flip_rate_lo = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      bit v, f, c, r, b;
      if (i % 500 == 0) begin
        flip_rate_hi = 1'($urandom % 2);
        flip_rate_lo = 1'($urandom % 2);
      end
      r = ($urandom % 700) == 0;
      v = ($urandom % 4) != 0;
      c = ($urandom % 150) == 0;
      f = flip_rate_hi ? (($urandom % 3) == 0) : (flip_rate_lo ? (($urandom % 40) == 0) : 1'b0);
      if (v) begin
        b = lfsr_adv(g_main) ^ f;
        step(r, 1'b1, b, c);
      end else begin
        step(r, 1'b0, 1'($urandom % 2), c);
      end
    end
  endtask

  task automatic sat_test();
    logic [15:0] gs;
    s_rst = 1'b1; s_vld = 1'b1; s_bit = 1'b0; s_clr = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    s_rst = 1'b0;
    gs = 16'he45b;
    for (int i = 0; i < 48; i++) begin
      s_bit = lfsr_adv(gs);
      @(posedge clk); #1;
    end
    chk("sat_locked", 64'(s_locked), 64'd1);
    for (int i = 1; i <= 65538; i++) begin
      s_bit = ~lfsr_adv(gs);
      @(posedge clk); #1;
      if (i == 1000)  chk("sat_err_1000", 64'(s_err_count), 64'd1000);
      if (i == 65534) chk("sat_err_fffe", 64'(s_err_count), 64'hFFFE);
      if (i == 65535) chk("sat_err_ffff", 64'(s_err_count), 64'hFFFF);
    end
    chk("sat_err_hold", 64'(s_err_count), 64'hFFFF);
    chk("sat_still_locked", 64'({s_locked, s_sync_state, s_err_pulse}), 64'({1'b1, 2'd2, 1'b1}));
    chk("sat_bitcount", 64'(s_bit_count), 64'd65538);
  endtask

  initial begin
    rst = 1'b1; in_vld = 1'b0; in_bit = 1'b0; clr = 1'b0;
    s_rst = 1'b1; s_vld = 1'b0; s_bit = 1'b0; s_clr = 1'b0;
    model_reset();
    fork
      main_test();
      sat_test();
    join
    $display("TB_RESULT checks=%0d failures=%0d", nchecks, nfail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "simulation time limit reached");
  end

endmodule
`default_nettype wire
